// File: rtl/shift_pkg.sv
// Op codes and engine state encoding shared by the shift engine and its step unit.
package shift_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
  localparam logic [2:0] OP_ASR = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ops that repeat `amt` single-bit steps; the rest complete on the accept edge.
  function automatic logic is_step_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step shift/rotate of the register value; zero latency.
// Non-step op codes pass the value through unchanged.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic             ser_in_lo,
  input  logic             ser_in_hi,
  output logic [WIDTH-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    case (op)
      OP_SHL:  q_nxt = {q[WIDTH-2:0], ser_in_lo};
      OP_SHR:  q_nxt = {ser_in_hi, q[WIDTH-1:1]};
      OP_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      OP_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_engine.sv
// Universal shift register: one op per valid/ready handshake, N steps take N cycles to done.
// op_ready is low while a multi-step op runs; requests are held off, never queued.
module univ_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_lo,
  input  logic             ser_in_hi,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_hi,
  output logic             ser_out_lo,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_nxt;

  // In RUN the latched op drives the step; in IDLE the incoming op does.
  assign step_op = (state_q == ST_RUN) ? op_q : op;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .op        (step_op),
    .q         (q_q),
    .ser_in_lo (ser_in_lo),
    .ser_in_hi (ser_in_hi),
    .q_nxt     (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          done_d = 1'b1;
          if (op == OP_LOAD) begin
            q_d = par_in;
          end else if (op == OP_CLR) begin
            q_d = '0;
          end else if (is_step_op(op) && (amt != '0)) begin
            q_d = step_nxt;
            if (amt != AMT_W'(1)) begin
              done_d  = 1'b0;
              op_d    = op;
              cnt_d   = amt - AMT_W'(1);
              state_d = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        q_d   = step_nxt;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q          = q_q;
  assign ser_out_hi = q_q[WIDTH-1];
  assign ser_out_lo = q_q[0];
  assign op_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Randomized scoreboard bench for univ_shift_engine against a bit-stream reference model.
module tb_univ_shift_engine;

  localparam int W = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  par_in = '0;
  logic          ser_in_lo = 1'b0;
  logic          ser_in_hi = 1'b0;
  logic [W-1:0]  q;
  logic          ser_out_hi;
  logic          ser_out_lo;
  logic          busy;
  logic          done;

  univ_shift_engine #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .amt        (amt),
    .par_in     (par_in),
    .ser_in_lo  (ser_in_lo),
    .ser_in_hi  (ser_in_hi),
    .q          (q),
    .ser_out_hi (ser_out_hi),
    .ser_out_lo (ser_out_lo),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] exp_q;
    int unsigned  acc_cyc;
    int unsigned  exp_lat;
    logic [2:0]   op;
  } sb_item_t;

  sb_item_t     sb[$];
  logic [W-1:0] mdl_q;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the register is a window onto a stream of bits; shifts slide the window.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input int n, input logic [W-1:0] v,
                                          input logic [15:0] lo, input logic [15:0] hi,
                                          input logic [W-1:0] p);
    longint ext;
    longint mask;
    int k;
    logic signed [W-1:0] sv;
    mask = (64'd1 << W) - 1;
    ext = 0;
    k = n % W;
    sv = v;
    case (o)
      3'd1: begin
        ext = longint'(v) << n;
        for (int i = 0; i < n; i++) ext = ext | (longint'(lo[i]) << (n - 1 - i));
        return W'(ext & mask);
      end
      3'd2: begin
        ext = longint'(v);
        for (int i = 0; i < n; i++) ext = ext | (longint'(hi[i]) << (W + i));
        return W'((ext >> n) & mask);
      end
      3'd3: return p;
      3'd4: return (k == 0) ? v : W'(((longint'(v) << k) | (longint'(v) >> (W - k))) & mask);
      3'd5: return (k == 0) ? v : W'(((longint'(v) >> k) | (longint'(v) << (W - k))) & mask);
      3'd6: return W'(sv >>> n);
      3'd7: return '0;
      default: return v;
    endcase
  endfunction

  task automatic monitor_loop();
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
        end else begin
          it = sb.pop_front();
          check($sformatf("q_op%0d", it.op), q, it.exp_q);
          check($sformatf("latency_op%0d", it.op), cyc - it.acc_cyc, it.exp_lat);
          check("ser_out_hi", ser_out_hi, it.exp_q[W-1]);
          check("ser_out_lo", ser_out_lo, it.exp_q[0]);
          check("busy_at_done", busy, 0);
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] o, input int n, input logic [W-1:0] p,
                       input logic [15:0] lo, input logic [15:0] hi);
    int waits;
    int steps;
    sb_item_t it;
    steps = ((o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5) || (o == 3'd6)) ? n : 0;
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    amt = AW'(n);
    par_in = p;
    ser_in_lo = lo[0];
    ser_in_hi = hi[0];
    waits = 0;
    while (!op_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("ready_at_issue", waits, 0);
    if (!op_ready) begin
      $display("FAIL accept_timeout: got op_ready=0, expected 1");
      n_fail++;
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    it.acc_cyc = cyc;
    it.exp_q = ref_op(o, n, mdl_q, lo, hi, p);
    it.exp_lat = (steps > 1) ? steps : 1;
    it.op = o;
    mdl_q = it.exp_q;
    sb.push_back(it);
    // While running, keep presenting junk requests; the engine must ignore them.
    for (int s = 1; s < steps; s++) begin
      @(negedge clk);
      ser_in_lo = lo[s];
      ser_in_hi = hi[s];
      op_valid = 1'b1;
      op = 3'($urandom);
      amt = AW'($urandom);
      par_in = W'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      op_valid = 1'b0;
      ser_in_lo = 1'($urandom);
      ser_in_hi = 1'($urandom);
    end
  endtask

  initial begin
    logic [2:0] ro;
    int wait_budget;
    fork
      monitor_loop();
    join_none

    mdl_q = '0;
    #7 reset = 1'b1;
    #1;
    check("rst_q", q, 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    issue(3'd3, 0, 8'hA5, 16'h0000, 16'h0000);
    issue(3'd1, 3, 8'h00, 16'hFFFF, 16'h0000);
    issue(3'd3, 0, 8'h81, 16'h0000, 16'h0000);
    issue(3'd5, 1, 8'h00, 16'h0000, 16'h0000);
    issue(3'd3, 0, 8'h81, 16'h0000, 16'h0000);
    issue(3'd5, 8, 8'h00, 16'h0000, 16'h0000);
    issue(3'd4, 0, 8'h00, 16'h0000, 16'h0000);
    issue(3'd3, 0, 8'h90, 16'h0000, 16'h0000);
    issue(3'd6, 2, 8'h00, 16'h0000, 16'h0000);
    issue(3'd3, 0, 8'hFF, 16'h0000, 16'h0000);
    issue(3'd2, 9, 8'h00, 16'h0000, 16'h0000);
    issue(3'd7, 5, 8'h00, 16'hFFFF, 16'hFFFF);
    issue(3'd0, 3, 8'h00, 16'h0000, 16'h0000);
    idle(2);

    // Reset in the middle of a 5-step SHR: no done may follow.
    issue(3'd3, 0, 8'hF0, 16'h0000, 16'h0000);
    @(negedge clk);
    op_valid = 1'b1;
    op = 3'd2;
    amt = AW'(5);
    ser_in_hi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midop_rst_q", q, 0);
    check("midop_rst_ready", op_ready, 1);
    check("midop_rst_busy", busy, 0);
    check("midop_rst_done", done, 0);
    mdl_q = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    issue(3'd3, 0, 8'h3C, 16'h0000, 16'h0000);

    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom);
      issue(ro, $urandom_range(0, 15), W'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    wait_budget = 0;
    while (sb.size() != 0 && wait_budget < 40) begin
      @(negedge clk);
      wait_budget++;
    end
    idle(3);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_engine.md
Name: univ_shift_engine

Overview:
- Parametrised universal shift register with a multi-cycle shift engine; successor to the 8-bit hold/shift/load register.
- Accepts one operation at a time over a valid/ready handshake: load, clear, logical shift either way, rotate either way, or arithmetic right shift, repeated `amt` times.
- Signals completion with a one-cycle `done` pulse.
- Sits between parallel datapath registers and serial links, and serves as a serializer/deserializer building block.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- AMT_W, 4, width of the shift-amount field

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, asynchronous, active-high
- op_valid  input  1  operation request
- op_ready  output  1  engine idle; request accepted when op_valid && op_ready
- op  input  3  operation code (see Behaviour)
- amt  input  AMT_W  number of single-bit steps for shift/rotate ops
- par_in  input  WIDTH  parallel load data
- ser_in_lo  input  1  fill bit entering bit 0 on SHL; sampled on every step
- ser_in_hi  input  1  fill bit entering bit WIDTH-1 on SHR; sampled on every step
- q  output  WIDTH  register contents
- ser_out_hi  output  1  q[WIDTH-1], combinational
- ser_out_lo  output  1  q[0], combinational
- busy  output  1  multi-step operation in progress
- done  output  1  one-cycle pulse after the final update of an operation

Behaviour:
- Reset (async, any time, including mid-operation):
  - q=0, state IDLE, busy=0, done=0, op_ready=1, step counter=0.
  - An interrupted operation produces no done pulse.
- Op encoding:
  - 0 NOP
  - 1 SHL: toward MSB, ser_in_lo enters bit 0
  - 2 SHR: toward LSB, ser_in_hi enters MSB
  - 3 LOAD: q=par_in
  - 4 ROL: MSB wraps to bit 0
  - 5 ROR: bit 0 wraps to MSB
  - 6 ASR: MSB replicated
  - 7 CLR: q=0
- States:
  - IDLE: op_ready=1, busy=0.
  - RUN: op_ready=0, busy=1.
- Accept edge (op_valid && op_ready):
  - NOP, LOAD, CLR: update q on the accept edge, stay IDLE, done=1 in the following cycle. amt is ignored.
  - Shift/rotate with amt=0: behaves as NOP; q unchanged, done pulse next cycle.
  - Shift/rotate with amt=1: one step on the accept edge, stay IDLE, done pulse next cycle.
  - Shift/rotate with amt=N>1: first step on the accept edge. Latch op and set cnt=N-1, then enter RUN.
- RUN:
  - One step per edge; cnt decrements each step.
  - On the edge where cnt goes 1->0, perform the last step and return to IDLE. done=1 for the next cycle only.
  - Total steps equal N exactly.
  - Latency from accept to done is N cycles.
- op_valid while in RUN is ignored. The requester must hold the op until it is accepted; no queueing.
- Serial inputs are sampled at every step edge, not latched at accept, which allows streaming.
- amt > WIDTH is executed literally, with no saturation or modulo:
  - SHL/SHR fully flush to fill bits.
  - ASR saturates to all-MSB.
  - Rotates wrap.
- done and op_ready can be high in the same cycle, so back-to-back ops are accepted with no bubble.
- A new accept in the done cycle is legal.
- par_in, op and amt are sampled only on the accept edge.

Decomposition:
- Package shift_pkg holds:
  - the op code localparams (OP_NOP … OP_CLR)
  - the state encoding (ST_IDLE, ST_RUN)
- Sub-module shift_step_unit:
  - purely combinational, parameter WIDTH
  - inputs: op, q, ser_in_lo, ser_in_hi
  - output: the one-step next value
- The top level contains only the handshake FSM, the counter and the q register.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> q=0x00, op_ready=1, busy=0, done=0 immediately, without waiting for a clock edge.
- LOAD par_in=0xA5 -> q=0xA5 after the accept edge; done high exactly 1 cycle; op_ready stays 1.
- SHL amt=3, ser_in_lo=1, from 0xA5 -> q steps 0x4B, 0x97, 0x2F; busy=1 for 2 cycles; done pulses in the cycle after q=0x2F; an op_valid during busy is ignored.
- ROR amt=1 on 0x81 -> 0xC0. ROR amt=8 on 0x81 -> 0x81 with done 8 cycles after accept. ROL amt=0 -> q unchanged, done next cycle.
- ASR amt=2 on 0x90 -> 0xC8 then 0xE4. SHR amt=9 with ser_in_hi=0 on 0xFF -> 0x00.
- SHR amt=5 on 0xF0, assert reset after 2 steps -> q=0x00, IDLE, no done pulse. After reset release, LOAD 0x3C is accepted on the first edge.
